// File: rtl/ka_pkg.sv
// Shared constants for the Kanalog I/O blocks.
package ka_pkg;

  localparam int unsigned KA_IN_W            = 16;
  localparam int unsigned KA_OUT_W           = 24;
  localparam int unsigned KA_CLK_HZ          = 66_500_000;
  localparam int unsigned KA_DB_PRESCALE_DEF = 665;
  localparam int unsigned KA_DB_COUNT_DEF    = 4;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned ka_cnt_w(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/ka_debounce_ch.sv
// One Kanalog input channel: 2-flop synchronizer plus tick-based debounce counter.
module ka_debounce_ch #(
  parameter int unsigned DB_COUNT = 4,
  parameter int unsigned CW       = 4
) (
  input  logic fpga_clk,
  input  logic kreset,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic flip
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DB_COUNT - 1);

  logic          sync1_q, sync2_q;
  logic          clean_q, clean_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    flip    = 1'b0;
    if (tick) begin
      if (sync2_q == clean_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        clean_d = ~clean_q;
        cnt_d   = '0;
        flip    = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Idle level is high to match the input pull-ups.
  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      clean_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  assign clean = clean_q;

endmodule

// File: rtl/ka_in_filter.sv
// Kanalog input conditioning: sync + per-channel debounce, chg pulse, optional change mask.
// Define KA_IN_FILTER_CHGMASK_EN to build the sticky change_mask cleared by snap.
module ka_in_filter
  import ka_pkg::*;
#(
  parameter int unsigned N        = KA_IN_W,
  parameter int unsigned PRESCALE = KA_DB_PRESCALE_DEF,
  parameter int unsigned DB_COUNT = KA_DB_COUNT_DEF,
  parameter int unsigned CW       = 4
) (
  input  logic         fpga_clk,
  input  logic         kreset,
  input  logic [N-1:0] raw_in,
  input  logic         snap,
  output logic [N-1:0] clean_out,
  output logic         chg,
  output logic [N-1:0] change_mask,
  output logic         tick
);

  localparam int unsigned    PW   = ka_cnt_w(PRESCALE - 1);
  localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          chg_q;
  logic [N-1:0]  flip;

  always_comb begin
    presc_d = (presc_q == PMAX) ? '0 : presc_q + PW'(1);
    tick_d  = (presc_q == PMAX);
  end

  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      chg_q   <= |flip;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    ka_debounce_ch #(
      .DB_COUNT (DB_COUNT),
      .CW       (CW)
    ) u_ch (
      .fpga_clk (fpga_clk),
      .kreset   (kreset),
      .raw      (raw_in[i]),
      .tick     (tick_q),
      .clean    (clean_out[i]),
      .flip     (flip[i])
    );
  end

`ifdef KA_IN_FILTER_CHGMASK_EN
  logic [N-1:0] mask_q, mask_d;

  // Set is applied after clear so a flip coinciding with snap survives the load.
  always_comb begin
    mask_d = (snap ? '0 : mask_q) | flip;
  end

  always_ff @(posedge fpga_clk or negedge kreset) begin
    if (!kreset) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign change_mask = mask_q;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign change_mask = '0;
`endif

  assign tick = tick_q;
  assign chg  = chg_q;

endmodule

// File: tb/tb_ka_in_filter.sv
// Scoreboard bench for ka_in_filter with PRESCALE=4, DB_COUNT=3.
module tb_ka_in_filter;

`ifdef KA_IN_FILTER_CHGMASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic        fpga_clk = 1'b0;
  logic        kreset   = 1'b0;
  logic        snap     = 1'b0;
  logic [15:0] raw_in   = '0;
  logic [15:0] clean_out;
  logic        chg;
  logic [15:0] change_mask;
  logic        tick;

  ka_in_filter #(
    .N        (16),
    .PRESCALE (4),
    .DB_COUNT (3),
    .CW       (4)
  ) dut (
    .fpga_clk    (fpga_clk),
    .kreset      (kreset),
    .raw_in      (raw_in),
    .snap        (snap),
    .clean_out   (clean_out),
    .chg         (chg),
    .change_mask (change_mask),
    .tick        (tick)
  );

  always #5 fpga_clk = ~fpga_clk;

  int unsigned cyc = 0;
  always @(posedge fpga_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] clean;
    logic [15:0] mask;
    int unsigned tmin;
    int unsigned tmax;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] exp_clean = '1;
  logic [15:0] exp_mask  = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic push(input logic [15:0] nc, input int unsigned tmin, input int unsigned tmax,
                      input bit snap_same);
    logic [15:0] flipped;
    flipped   = nc ^ exp_clean;
    exp_mask  = MASK_EN ? ((snap_same ? 16'h0000 : exp_mask) | flipped) : 16'h0000;
    exp_clean = nc;
    q.push_back('{nc, exp_mask, tmin, tmax});
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int unsigned i = 0; i < budget && q.size() != 0; i++) @(negedge fpga_clk);
    @(negedge fpga_clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", q.size());
      q.delete();
    end
  endtask

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge fpga_clk);
      if (tick) seen = 1'b1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL tick_seen got=0 want=1");
    end
  endtask

  task automatic do_snap();
    @(negedge fpga_clk);
    snap = 1'b1;
    @(negedge fpga_clk);
    snap = 1'b0;
    exp_mask = '0;
    check("snap_clear_mask", change_mask, exp_mask);
  endtask

  // Monitor: every chg pulse must match the next expected flip.
  always @(negedge fpga_clk) begin
    if (kreset && chg) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_chg clean_out=%h want no pulse", clean_out);
      end else begin
        mon_e = q.pop_front();
        check("sb_clean", clean_out, mon_e.clean);
        check("sb_mask", change_mask, mon_e.mask);
        tests++;
        if (cyc < mon_e.tmin || cyc > mon_e.tmax) begin
          fails++;
          $display("FAIL sb_latency got cyc=%0d want %0d..%0d", cyc, mon_e.tmin, mon_e.tmax);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    int          nt;

    // Reset state with inputs held low
    repeat (3) @(negedge fpga_clk);
    check("rst_clean", clean_out, 16'hFFFF);
    check("rst_chg", chg, 0);
    check("rst_mask", change_mask, 16'h0000);
    check("rst_tick", tick, 0);
    kreset = 1'b1;
    c = cyc;
    push(16'h0000, c + 1, c + 15, 1'b0);
    wait_drain(30);

    nt = 0;
    repeat (40) begin
      @(negedge fpga_clk);
      if (tick) nt++;
    end
    check("tick_count", nt, 10);

    @(negedge fpga_clk);
    raw_in = 16'hFFFF;
    c = cyc;
    push(16'hFFFF, c + 11, c + 15, 1'b0);
    wait_drain(30);
    do_snap();

    // Glitch shorter than 3 ticks
    @(negedge fpga_clk);
    raw_in[5] = 1'b0;
    repeat (7) @(negedge fpga_clk);
    raw_in[5] = 1'b1;
    repeat (30) @(negedge fpga_clk);
    check("glitch_clean", clean_out, 16'hFFFF);

    // Accept a held level, then return
    @(negedge fpga_clk);
    raw_in[0] = 1'b0;
    c = cyc;
    push(16'hFFFE, c + 11, c + 15, 1'b0);
    repeat (20) @(negedge fpga_clk);
    raw_in[0] = 1'b1;
    c = cyc;
    push(16'hFFFF, c + 11, c + 15, 1'b0);
    wait_drain(30);

    // Twelve channels fall together
    @(negedge fpga_clk);
    raw_in = 16'h00F0;
    c = cyc;
    push(16'h00F0, c + 11, c + 15, 1'b0);
    wait_drain(30);
    check("multi_clean", clean_out, 16'h00F0);
    @(negedge fpga_clk);
    raw_in = 16'hFFFF;
    c = cyc;
    push(16'hFFFF, c + 11, c + 15, 1'b0);
    wait_drain(30);

    // Change mask: bit 3 flip, then bit 9 flip coinciding with snap
    do_snap();
    @(negedge fpga_clk);
    raw_in[3] = 1'b0;
    c = cyc;
    push(16'hFFF7, c + 11, c + 15, 1'b0);
    wait_drain(30);
    wait_tick();
    raw_in[9] = 1'b0;
    c = cyc;
    push(16'hFDF7, c + 13, c + 13, 1'b1);
    repeat (12) @(posedge fpga_clk);
    @(negedge fpga_clk);
    snap = 1'b1;
    @(negedge fpga_clk);
    snap = 1'b0;
    wait_drain(5);
    check("mask_after_coincide", change_mask, MASK_EN ? 16'h0200 : 16'h0000);
    do_snap();
    @(negedge fpga_clk);
    raw_in = 16'hFFFF;
    c = cyc;
    push(16'hFFFF, c + 11, c + 15, 1'b0);
    wait_drain(30);
    do_snap();

    // Reset after two of three ticks discards the partial count
    wait_tick();
    raw_in[1] = 1'b0;
    repeat (10) @(posedge fpga_clk);
    @(negedge fpga_clk);
    check("pre_reset_clean", clean_out, 16'hFFFF);
    kreset    = 1'b0;
    exp_clean = '1;
    exp_mask  = '0;
    repeat (2) @(negedge fpga_clk);
    check("midrst_clean", clean_out, 16'hFFFF);
    check("midrst_mask", change_mask, 16'h0000);
    kreset = 1'b1;
    c = cyc;
    push(16'hFFFD, c + 11, c + 15, 1'b0);
    wait_drain(30);

    @(negedge fpga_clk);
    raw_in = 16'hFFFF;
    c = cyc;
    push(16'hFFFF, c + 11, c + 15, 1'b0);
    wait_drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ka_in_filter.md
# ka_in_filter

Input conditioning stage that sits directly upstream of the Kanalog input parallel-load shift register. It synchronizes the 16 raw Kanalog digital inputs into the fpga_clk domain and debounces each channel with a tick-based, per-channel counter. It presents a stable parallel word to the input latch. Optionally, it records which channels changed since the last parallel load.

## Interface
- N, 16, channel count.
- PRESCALE, 665, fpga_clk cycles per debounce tick; 665 gives 10 µs at 66.5 MHz; minimum 1.
- DB_COUNT, 4, consecutive differing ticks required to accept a new level; range 1..15.
- CW, 4, per-channel counter width; must satisfy 2^CW > DB_COUNT.

Ports:
- fpga_clk  in  1  single system clock, 66.5 MHz internal oscillator.
- kreset  in  1  master reset; asynchronous, active-low.
- raw_in  in  N  asynchronous Kanalog inputs (ka_in pins).
- snap  in  1  one-cycle pulse, high when the downstream latch parallel-loads clean_out; driven by the falling edge of the serial-load strobe.
- clean_out  out  N  debounced level per channel; feeds the latch p_in.
- chg  out  1  one-cycle pulse when any clean_out bit flips.
- change_mask  out  N  sticky per-channel change flags (see Configuration).
- tick  out  1  debounce tick strobe; exported for test and monitoring.

## Operation
- Reset (kreset low, asynchronous):
  - clean_out = all ones, matching the idle-high input pull-ups.
  - Both sync stages = all ones.
  - Prescaler = 0, all counters = 0.
  - chg = 0, change_mask = 0, tick = 0.
- Synchronizer: a 2-flop chain per bit; sync[i] is raw_in[i] delayed by 2 clocks.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps to 0.
  - tick is registered and high for exactly one clock when the count equals PRESCALE-1.
  - PRESCALE=1 gives tick high every clock.
- Per-channel debounce, evaluated only on clocks where tick=1:
  - If sync[i]==clean_out[i]: cnt[i] = 0.
  - Else, if cnt[i]==DB_COUNT-1: clean_out[i] flips and cnt[i] = 0.
  - Else: cnt[i] increments.
  - A level must therefore differ on DB_COUNT consecutive ticks to be accepted.
  - Any matching tick in between restarts the count, so glitches lasting fewer than DB_COUNT ticks are rejected.
- chg is registered alongside clean_out. It is 1 on the same clock clean_out changes and covers the OR of all flipping channels.
- Channels are fully independent. Simultaneous flips on several channels produce a single chg pulse.
- The counter cannot overflow: cnt saturates by construction at DB_COUNT-1.

## Timing
- clean_out, chg, change_mask and tick are all registered outputs. There is no combinational path from any input to any output.
- Acceptance latency from a raw_in edge to the clean_out change:
  - Minimum: 2 + (DB_COUNT-1)*PRESCALE + 1 clocks.
  - Maximum: 2 + DB_COUNT*PRESCALE + 1 clocks, depending on tick phase.
- snap takes effect on the clock it is sampled high, and only the change_mask update depends on it.
- Reset asserted mid-debounce discards all partial counts. After release, the first tick occurs PRESCALE clocks later.

## Configuration
- KA_IN_FILTER_CHGMASK_EN defined:
  - change_mask[i] is set on a clock where clean_out[i] flips.
  - change_mask is cleared to 0 on a clock where snap=1.
  - When set and snap coincide, the set wins: the bit ends at 1, so no flip is lost across a load.
- KA_IN_FILTER_CHGMASK_EN undefined:
  - change_mask is tied to 0 and snap is ignored.
  - No mask registers are synthesized.
  - All other behaviour is identical.

## Structure
- Package ka_pkg holds:
  - KA_IN_W = 16 and KA_OUT_W = 24.
  - KA_CLK_HZ = 66_500_000.
  - KA_DB_PRESCALE_DEF = 665 and KA_DB_COUNT_DEF = 4.
- Sub-module ka_debounce_ch implements one channel: the 2-flop sync, cnt, and clean bit. It has ports for fpga_clk, kreset, raw, tick, clean and flip, and ka_in_filter instantiates it N times.
- ka_in_filter owns the prescaler, the chg OR-reduce and the change_mask logic.

## Test plan
Use PRESCALE=4 and DB_COUNT=3 unless stated.
- Reset: raw_in = 16'h0000 held during kreset low -> clean_out = 16'hFFFF, chg = 0, change_mask = 0. After release, clean_out reaches 16'h0000 within 2+12+1 clocks, with one chg pulse.
- Glitch reject: raw_in[5] pulsed low for 7 clocks (fewer than 3 ticks) -> clean_out[5] stays 1, no chg pulse.
- Accept: raw_in[0] held low for 20 clocks -> clean_out[0] falls between clock 11 and clock 15 after the edge, with exactly one chg pulse.
- Multi-channel: raw_in 16'hFFFF -> 16'h00F0 in a single clock -> all twelve falling bits flip on the same clock, with one chg pulse.
- Change mask (macro on): flip bit 3, then pulse snap on the same clock as a flip of bit 9 -> change_mask = 16'h0200 after that clock. A second snap clears it to 16'h0000. With the macro off, change_mask stays 0 throughout.
- Reset mid-count: assert kreset after 2 of 3 ticks -> after release, the input must again persist for a full 3 ticks before clean_out changes.
